// File: rtl/tm1638_disp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_disp_seq
// Brief    : Bus-master sequencer that writes a hex value, LEDs and config
//            into a TM1638 register window and polls its button register.
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_disp_seq #(
    parameter logic [11:0] BASE_ADDR   = 12'hff0,
    parameter logic [15:0] IDLE_ADDR   = 16'h0000,
    parameter int          POLL_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        update,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  leds_in,
    input  logic        blank_lz,
    input  logic        disp_on,
    input  logic [2:0]  bright,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_wr,
    output logic        bus_rd,
    input  logic [7:0]  bus_din,
    output logic        busy,
    output logic        done,
    output logic [7:0]  buttons,
    output logic [7:0]  btn_press,
    output logic        btn_valid
);

    localparam int                 c_CNT_W   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(POLL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_DIG = 3'd1,
        ST_WR_LED = 3'd2,
        ST_WR_CFG = 3'd3,
        ST_RD_BTN = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic               r_is_upd;
    logic               r_upd_pend;
    logic               r_poll_pend;
    logic [c_CNT_W-1:0] r_poll_cnt;
    logic [31:0]        r_value;
    logic [7:0]         r_dp;
    logic [7:0]         r_leds;
    logic               r_blank;
    logic               r_disp_on;
    logic [2:0]         r_bright;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Shifting the digit's nibble to the bottom leaves exactly it and the
    // more-significant nibbles, so a zero result means "still a leading zero".
    function automatic logic [7:0] dig_byte(input logic [31:0] v, input logic [7:0] d,
                                            input logic bl, input logic [2:0] idx);
        logic [4:0]  shamt;
        logic [31:0] upper;
        logic [6:0]  seg;
        shamt = {~idx, 2'b00};
        upper = v >> shamt;
        if (bl && (idx != 3'd7) && (upper == 32'd0))
            seg = 7'd0;
        else
            seg = seg_of(upper[3:0]);
        return {d[~idx], seg};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_is_upd    <= 1'b0;
            r_upd_pend  <= 1'b0;
            r_poll_pend <= 1'b0;
            r_poll_cnt  <= '0;
            r_value     <= 32'd0;
            r_dp        <= 8'd0;
            r_leds      <= 8'd0;
            r_blank     <= 1'b0;
            r_disp_on   <= 1'b0;
            r_bright    <= 3'd0;
            bus_addr    <= IDLE_ADDR;
            bus_dout    <= 8'd0;
            bus_wr      <= 1'b0;
            bus_rd      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            buttons     <= 8'd0;
            btn_press   <= 8'd0;
            btn_valid   <= 1'b0;
        end else begin
            if (r_poll_cnt == c_CNT_MAX)
                r_poll_cnt <= '0;
            else
                r_poll_cnt <= r_poll_cnt + c_CNT_ONE;

            done      <= 1'b0;
            btn_valid <= 1'b0;
            btn_press <= 8'd0;

            case (r_state)
                ST_IDLE: begin
                    if (update || r_upd_pend) begin
                        r_value    <= value;
                        r_dp       <= dp;
                        r_leds     <= leds_in;
                        r_blank    <= blank_lz;
                        r_disp_on  <= disp_on;
                        r_bright   <= bright;
                        r_upd_pend <= 1'b0;
                        r_is_upd   <= 1'b1;
                        r_idx      <= 3'd0;
                        r_state    <= ST_WR_DIG;
                        busy       <= 1'b1;
                        bus_wr     <= 1'b1;
                        bus_addr   <= {BASE_ADDR, 4'h0};
                        bus_dout   <= dig_byte(value, dp, blank_lz, 3'd0);
                    end else if (r_poll_pend) begin
                        r_is_upd <= 1'b0;
                        r_state  <= ST_RD_BTN;
                        busy     <= 1'b1;
                        bus_rd   <= 1'b1;
                        bus_addr <= {BASE_ADDR, 4'h9};
                    end
                end
                ST_WR_DIG: begin
                    if (r_idx == 3'd7) begin
                        r_state  <= ST_WR_LED;
                        bus_addr <= {BASE_ADDR, 4'h8};
                        bus_dout <= r_leds;
                    end else begin
                        r_idx    <= r_idx + 3'd1;
                        bus_addr <= {BASE_ADDR, 1'b0, r_idx + 3'd1};
                        bus_dout <= dig_byte(r_value, r_dp, r_blank, r_idx + 3'd1);
                    end
                end
                ST_WR_LED: begin
                    r_state  <= ST_WR_CFG;
                    bus_addr <= {BASE_ADDR, 4'hF};
                    bus_dout <= {4'b0000, r_disp_on, r_bright};
                end
                ST_WR_CFG: begin
                    r_state  <= ST_RD_BTN;
                    bus_wr   <= 1'b0;
                    bus_rd   <= 1'b1;
                    bus_dout <= 8'd0;
                    bus_addr <= {BASE_ADDR, 4'h9};
                end
                ST_RD_BTN: begin
                    r_state   <= ST_FIN;
                    bus_rd    <= 1'b0;
                    bus_addr  <= IDLE_ADDR;
                    buttons   <= bus_din;
                    btn_press <= bus_din & ~buttons;
                    btn_valid <= 1'b1;
                    done      <= r_is_upd;
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase

            if ((r_state != ST_IDLE) && update)
                r_upd_pend <= 1'b1;

            // A wrap landing on FIN happened after the read, so it survives.
            if (r_poll_cnt == c_CNT_MAX)
                r_poll_pend <= 1'b1;
            else if (r_state == ST_FIN)
                r_poll_pend <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tm1638_disp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_disp_seq
// Brief    : Self-checking bench for tm1638_disp_seq against a per-sequence
//            offset model of the bus traffic and button polling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm1638_disp_seq;

    localparam logic [11:0] BASE_A = 12'hff0;
    localparam logic [15:0] IDLE_A = 16'h0000;
    localparam int          POLL   = 16;

    logic        clk = 1'b0;
    logic        reset_n, update, blank_lz, disp_on;
    logic [31:0] value;
    logic [7:0]  dp, leds_in, slave_btn;
    logic [2:0]  bright;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din, buttons, btn_press;
    logic        bus_wr, bus_rd, busy, done, btn_valid;

    assign bus_din = (bus_addr == {BASE_A, 4'h9}) ? slave_btn : 8'hEE;

    tm1638_disp_seq #(
        .BASE_ADDR  (BASE_A),
        .IDLE_ADDR  (IDLE_A),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .update   (update),
        .value    (value),
        .dp       (dp),
        .leds_in  (leds_in),
        .blank_lz (blank_lz),
        .disp_on  (disp_on),
        .bright   (bright),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_wr   (bus_wr),
        .bus_rd   (bus_rd),
        .bus_din  (bus_din),
        .busy     (busy),
        .done     (done),
        .buttons  (buttons),
        .btn_press(btn_press),
        .btn_valid(btn_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int r0       = 0;
    int last_done  = -1;
    int last_valid = -1;

    // reference model: an active sequence is described by its start cycle
    bit          m_act = 0, m_upd = 0, m_upd_pend = 0, m_poll_pend = 0;
    int          m_start = 0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_dp = '0, m_leds = '0, m_btn = '0, m_press = '0;
    logic        m_blank = 0, m_on = 0;
    logic [2:0]  m_bright = '0;

    logic        p_rst, p_upd, p_blank, p_on;
    logic [31:0] p_value;
    logic [7:0]  p_dp, p_leds, p_slave;
    logic [2:0]  p_bright;

    logic [23:0] wr_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_dig(input logic [31:0] v, input logic [7:0] d,
                                           input logic bl, input int i);
        int nlz = 0;
        bit run = 1;
        logic [3:0] nib;
        for (int j = 0; j < 8; j++) begin
            nib = v[31-4*j -: 4];
            if (run && nib == 4'h0) nlz++;
            else run = 0;
        end
        nib = v[31-4*i -: 4];
        return ((bl && i < 7 && i < nlz) ? 8'h00 : seg_tab[nib]) | {d[7-i], 7'b0};
    endfunction

    task automatic advance();
        int k, last;
        bit wrap;
        if (!p_rst) begin
            m_act = 0; m_upd_pend = 0; m_poll_pend = 0; m_btn = '0; m_press = '0;
            r0 = cyc;
        end else begin
            wrap = (((cyc - 1 - r0) % POLL) == POLL - 1);
            if (!m_act) begin
                if (p_upd || m_upd_pend) begin
                    m_act = 1; m_upd = 1; m_start = cyc - 1; m_upd_pend = 0;
                    m_val = p_value; m_dp = p_dp; m_leds = p_leds;
                    m_blank = p_blank; m_on = p_on; m_bright = p_bright;
                end else if (m_poll_pend) begin
                    m_act = 1; m_upd = 0; m_start = cyc - 1;
                end
            end else begin
                k = cyc - 1 - m_start;
                last = m_upd ? 12 : 2;
                if (p_upd) m_upd_pend = 1;
                if (k == last - 1) begin
                    m_press = p_slave & ~m_btn;
                    m_btn = p_slave;
                end
                if (k == last) begin
                    m_act = 0; m_poll_pend = 0;
                end
            end
            if (wrap) m_poll_pend = 1;
        end
    endtask

    task automatic check_outputs();
        logic        e_wr, e_rd, e_busy, e_done, e_valid;
        logic [15:0] e_addr;
        logic [7:0]  e_dout, e_press;
        int k;
        e_wr = 0; e_rd = 0; e_busy = 0; e_done = 0; e_valid = 0;
        e_addr = IDLE_A; e_dout = '0; e_press = '0;
        if (m_act) begin
            k = cyc - m_start;
            e_busy = 1;
            if (m_upd) begin
                if (k >= 1 && k <= 8) begin
                    e_wr = 1; e_addr = {BASE_A, 4'(k - 1)};
                    e_dout = exp_dig(m_val, m_dp, m_blank, k - 1);
                end else if (k == 9) begin
                    e_wr = 1; e_addr = {BASE_A, 4'h8}; e_dout = m_leds;
                end else if (k == 10) begin
                    e_wr = 1; e_addr = {BASE_A, 4'hF}; e_dout = {4'b0, m_on, m_bright};
                end else if (k == 11) begin
                    e_rd = 1; e_addr = {BASE_A, 4'h9};
                end else if (k == 12) begin
                    e_done = 1; e_valid = 1; e_press = m_press;
                end
            end else begin
                if (k == 1) begin
                    e_rd = 1; e_addr = {BASE_A, 4'h9};
                end else if (k == 2) begin
                    e_valid = 1; e_press = m_press;
                end
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("bus_wr", 32'(bus_wr), 32'(e_wr));
        chk("bus_rd", 32'(bus_rd), 32'(e_rd));
        chk("bus_addr", 32'(bus_addr), 32'(e_addr));
        if (e_wr) chk("bus_dout", 32'(bus_dout), 32'(e_dout));
        chk("done", 32'(done), 32'(e_done));
        chk("btn_valid", 32'(btn_valid), 32'(e_valid));
        chk("buttons", 32'(buttons), 32'(m_btn));
        chk("btn_press", 32'(btn_press), 32'(e_press));
    endtask

    task automatic step();
        p_rst = reset_n; p_upd = update; p_value = value; p_dp = dp; p_leds = leds_in;
        p_blank = blank_lz; p_on = disp_on; p_bright = bright; p_slave = slave_btn;
        @(posedge clk);
        #1;
        cyc++;
        advance();
        check_outputs();
        if (bus_wr === 1'b1) wr_log.push_back({bus_addr, bus_dout});
        if (done === 1'b1) last_done = cyc;
        if (btn_valid === 1'b1) last_valid = cyc;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((m_act || m_poll_pend || m_upd_pend) && n < 40) begin
            step();
            n++;
        end
        chk("wait_quiet", 32'(m_act || m_poll_pend || m_upd_pend), 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            step();
            n++;
        end while (btn_valid !== 1'b1 && n < 40);
        chk("wait_valid", 32'(btn_valid), 32'd1);
    endtask

    logic [23:0] exp1 [10] = '{24'hFF003F, 24'hFF0106, 24'hFF025B, 24'hFF034F, 24'hFF0477,
                               24'hFF057C, 24'hFF0639, 24'hFF075E, 24'hFF085A, 24'hFF0F0D};
    logic [23:0] exp2 [8]  = '{24'hFF0000, 24'hFF0100, 24'hFF0200, 24'hFF0300,
                               24'hFF0400, 24'hFF0500, 24'hFF06ED, 24'hFF073F};

    initial begin
        int t, c1, n;
        logic [23:0] got;

        reset_n = 0; update = 0; value = '0; dp = '0; leds_in = '0; blank_lz = 0;
        disp_on = 0; bright = '0; slave_btn = '0;
        repeat (3) step();
        chk("rst_addr", 32'(bus_addr), 32'(IDLE_A));
        chk("rst_buttons", 32'(buttons), 32'd0);
        reset_n = 1;

        // basic update
        wait_quiet();
        wr_log.delete();
        value = 32'h0123ABCD; dp = 8'h00; blank_lz = 0; leds_in = 8'h5A;
        disp_on = 1; bright = 3'd5; update = 1;
        t = cyc;
        step();
        update = 0;
        repeat (12) step();
        chk("t1_done_cycle", 32'(last_done), 32'(t + 12));
        chk("t1_nwrites", 32'(wr_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : 24'h0;
            chk("t1_write", 32'(got), 32'(exp1[i]));
        end

        // leading-zero blanking with a decimal point on a blanked neighbour
        wait_quiet();
        wr_log.delete();
        value = 32'h00000050; dp = 8'h02; blank_lz = 1; update = 1;
        step();
        update = 0;
        repeat (12) step();
        for (int i = 0; i < 8; i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : 24'h0;
            chk("t2_digit", 32'(got), 32'(exp2[i]));
        end

        // periodic polling and press edges
        wait_quiet();
        slave_btn = 8'h00;
        wait_valid();
        slave_btn = 8'h05;
        wait_valid();
        c1 = last_valid;
        chk("poll_buttons_05", 32'(buttons), 32'h05);
        chk("poll_press_05", 32'(btn_press), 32'h05);
        chk("poll_done_low", 32'(done), 32'd0);
        slave_btn = 8'h04;
        wait_valid();
        chk("poll_buttons_04", 32'(buttons), 32'h04);
        chk("poll_press_00", 32'(btn_press), 32'h00);
        chk("poll_period", 32'(last_valid - c1), 32'd16);

        // requests during a sequence coalesce into one rerun
        wait_quiet();
        value = 32'h11111111; dp = 8'h00; blank_lz = 0; update = 1;
        t = cyc;
        step();
        update = 0;
        repeat (2) step();
        update = 1; step(); update = 0;
        repeat (3) step();
        update = 1; step(); update = 0;
        value = 32'h70000000;
        repeat (5) step();
        chk("coal_gap_busy", 32'(busy), 32'd0);
        chk("coal_gap_cycle", 32'(cyc), 32'(t + 13));
        step();
        chk("coal_rerun_wr", 32'(bus_wr), 32'd1);
        chk("coal_rerun_addr", 32'(bus_addr), 32'hFF00);
        chk("coal_rerun_dout", 32'(bus_dout), 32'h07);
        repeat (20) step();

        // poll pending and update in the same idle cycle
        n = 0;
        while (!(m_poll_pend && !m_act && !m_upd_pend) && n < 40) begin
            step();
            n++;
        end
        chk("pu_found", 32'(m_poll_pend && !m_act), 32'd1);
        value = 32'hCAFE0042; update = 1;
        t = cyc;
        step();
        update = 0;
        chk("pu_upd_first", 32'(bus_wr), 32'd1);
        repeat (12) step();
        chk("pu_done_cycle", 32'(last_done), 32'(t + 12));
        for (int i = 0; i < 3; i++) begin
            chk("pu_no_poll", 32'(busy), 32'd0);
            step();
        end

        // reset in the middle of a sequence
        wait_quiet();
        update = 1;
        t = cyc;
        step();
        update = 0;
        repeat (4) step();
        reset_n = 0;
        step();
        chk("rst_mid_wr", 32'(bus_wr), 32'd0);
        chk("rst_mid_addr", 32'(bus_addr), 32'(IDLE_A));
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset_n = 1;
        last_done = -1;
        repeat (20) step();
        chk("rst_no_done", 32'(last_done), 32'hFFFFFFFF);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            update = ($urandom_range(0, 9) == 0);
            value = $urandom;
            if ($urandom_range(0, 2) == 0) value = value >> (4 * $urandom_range(1, 7));
            dp = 8'($urandom);
            leds_in = 8'($urandom);
            blank_lz = 1'($urandom);
            disp_on = 1'($urandom);
            bright = 3'($urandom);
            if ($urandom_range(0, 4) == 0) slave_btn = 8'($urandom);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1; update = 0;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tm1638_disp_seq.md
Name: tm1638_disp_seq

Overview:
- Bus-master sequencer for the TM1638 register-mapped peripheral.
- Converts a 32-bit hex value, decimal points, LED pattern and display config into register writes on the 8-bit peripheral bus.
- Polls the button register periodically and reports debounced-by-poll state and press edges.
- Frees the CPU from per-digit writes; sits between application logic and the TM1638 bus slave.

Parameters:
- BASE_ADDR, 12'hff0, addr[15:4] of the TM1638 register window.
- IDLE_ADDR, 16'h0000, address driven when no bus cycle is active; IDLE_ADDR[15:4] must differ from BASE_ADDR.
- POLL_CYCLES, 500000, clk cycles between button polls (≥ 16).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- update  in  1  one-cycle request to refresh the display from the inputs below
- value  in  32  hex value; value[31:28] goes to dig_1 (leftmost), value[3:0] to dig_8
- dp  in  8  decimal point per digit; dp[7] goes to dig_1, dp[0] to dig_8
- leds_in  in  8  LED pattern
- blank_lz  in  1  1 = blank leading zero digits
- disp_on  in  1  display enable
- bright  in  3  brightness 0..7
- bus_addr  out  16  peripheral address
- bus_dout  out  8  write data to the slave
- bus_wr  out  1  write strobe, one cycle per write
- bus_rd  out  1  read strobe
- bus_din  in  8  read data from the slave, combinational from bus_addr
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at the end of an update sequence
- buttons  out  8  last polled button byte
- btn_press  out  8  one-cycle per-bit rising edges of buttons
- btn_valid  out  1  one-cycle pulse when buttons is refreshed

Behaviour:
- Register offsets:
  - 0..7 = dig_1..dig_8
  - 8 = leds
  - 9 = buttons (read)
  - F = {4'b0, disp_on, bright}
- Reset values:
  - bus_addr = IDLE_ADDR; bus_dout = 0; bus_wr = 0; bus_rd = 0
  - busy = 0; done = 0; buttons = 0; btn_press = 0; btn_valid = 0
  - Both pending flags cleared; poll counter = 0; state IDLE.
- States:
  - IDLE
  - WR_DIG: 8 cycles, index 0..7
  - WR_LED
  - WR_CFG
  - RD_BTN
  - FIN
- update handling:
  - In IDLE, update or upd_pend snapshots value, dp, leds_in, blank_lz, disp_on and bright into internal registers, clears upd_pend, and moves to WR_DIG.
  - update while busy sets upd_pend. Multiple requests coalesce into one rerun using the inputs present when that rerun starts.
- Update timing, with the update accepted in cycle t:
  - t+1..t+8: bus_wr=1, bus_addr={BASE_ADDR, idx}, bus_dout = seg(nibble) | (dp bit << 7)
  - t+9: WR_LED, address offset 8
  - t+10: WR_CFG, offset F
  - t+11: RD_BTN, bus_rd=1, offset 9; bus_din captured at the end of the cycle
  - t+12: FIN; done=1, btn_valid=1, buttons updated, btn_press = new & ~old; back to IDLE. Poll pending is cleared, because this read satisfies it.
  - busy=1 from t+1 through t+12.
- Segment encoding, bit0=a … bit6=g, bit7=dp:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking (blank_lz=1):
  - dig_1..dig_7 get segment byte 00 while its nibble and all more-significant nibbles are 0.
  - The dp bit is still applied on blanked digits.
  - dig_8 is never blanked.
- Poll counter:
  - Free-runs in every state, 0..POLL_CYCLES-1, then wraps.
  - On wrap it sets poll_pend.
  - In IDLE with poll_pend set and no update/upd_pend: go to RD_BTN (busy=1), then FIN. FIN here gives btn_valid=1, done=0.
  - Update has priority over poll when both are eligible in the same IDLE cycle.
- Bus outputs outside write/read states: IDLE_ADDR, strobes 0. bus_wr and bus_rd are never both 1.
- reset_n low mid-sequence: abort immediately to reset values in the next cycle; no further bus strobes are issued.

Test Plan:
- Reset, then update with value=32'h0123ABCD, dp=8'h00, blank_lz=0, leds_in=8'h5A, disp_on=1, bright=5 -> writes 3F,06,5B,4F,77,7C,39,5E to FF0..FF7 on cycles t+1..t+8; 5A to FF8; 0D to FFF; rd at FF9; done at t+12.
- value=32'h00000050, blank_lz=1, dp=8'h02 -> dig_1..dig_6 = 00; dig_7 = 6D|80 = ED; dig_8 = 3F.
- Slave returns 8'h00, then 8'h05, then 8'h04 on three successive polls (POLL_CYCLES=16) -> btn_press = 05 after the second poll and 00 after the third; buttons tracks the read values; btn_valid pulses every 16 cycles with done=0.
- update pulses at t+3 and t+7 during a sequence -> exactly one rerun starts the cycle after the first FIN, using the inputs sampled at its start.
- Poll wrap and update in the same IDLE cycle -> update sequence runs, with no separate poll read afterwards.
- Assert reset_n at t+5 -> next cycle: bus_wr=0, bus_addr=IDLE_ADDR, busy=0; no done pulse.
